// File: rtl/CpuPkg.sv
// -----------------------------------------------------------------------------
// CpuPkg
// Shared decode-path types for the CPU front end.
//   imm_type_e     : immediate format selector (I/S/B/U/J/CSR). The 3-bit
//                    encoding leaves 3'd6 and 3'd7 unused; those are the
//                    "unsupported" types that the decoder flags as illegal.
//   inst_t         : raw 32-bit instruction word.
//   IMM_CSR_W      : width of the CSR zero-extended immediate (uimm field).
//   stage_state_e  : occupancy state of the immediate-decode skid buffer.
// -----------------------------------------------------------------------------
package CpuPkg;

    typedef enum logic [2:0] {
        IMM_TYPE_I   = 3'd0,
        IMM_TYPE_S   = 3'd1,
        IMM_TYPE_B   = 3'd2,
        IMM_TYPE_U   = 3'd3,
        IMM_TYPE_J   = 3'd4,
        IMM_TYPE_CSR = 3'd5
    } imm_type_e;

    typedef logic [31:0] inst_t;

    localparam int IMM_CSR_W = 5;

    // EMPTY: nothing buffered. ONE: output register full. FULL: output and
    // skid register both full.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

endpackage : CpuPkg

// File: rtl/imm_decode_stage_if.sv
// -----------------------------------------------------------------------------
// imm_decode_stage_if
// Bundle of the flush, input handshake, output handshake and data signals of
// the immediate-decode stage.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer that raises valid keeps it and
// its data stable until the transfer. ready may change freely while valid is
// low. The stage's o_ready never depends combinationally on i_ready.
//
// Signals:
//   i_flush     drop all buffered entries (wins over any handshake)
//   i_valid     upstream offers an instruction
//   o_ready     stage can accept
//   i_imm_type  immediate format of the offered instruction
//   i_inst      raw instruction word
//   i_tag       sideband tag, passed through unchanged
//   o_valid     output entry present
//   i_ready     downstream accepts
//   o_imm       extended immediate
//   o_tag       tag of the output entry
//   o_illegal   output entry carried an unsupported immediate type
// Modports: slave = the stage, master = the environment driving it.
// -----------------------------------------------------------------------------
interface imm_decode_stage_if
    import CpuPkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) ();

    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    imm_type_e        i_imm_type;
    inst_t            i_inst;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_imm;
    logic [TAG_W-1:0] o_tag;
    logic             o_illegal;

    modport slave (
        input  i_flush, i_valid, i_imm_type, i_inst, i_tag, i_ready,
        output o_ready, o_valid, o_imm, o_tag, o_illegal
    );

    modport master (
        output i_flush, i_valid, i_imm_type, i_inst, i_tag, i_ready,
        input  o_ready, o_valid, o_imm, o_tag, o_illegal
    );

endinterface : imm_decode_stage_if

// File: rtl/imm_extract.sv
// -----------------------------------------------------------------------------
// imm_extract
// Purely combinational immediate extraction for one instruction word.
//   imm_type_i  in  immediate format
//   inst_i      in  raw instruction word
//   imm_o       out immediate extended to XLEN
//   illegal_o   out 1 when imm_type_i is not a supported format (imm_o = 0)
// -----------------------------------------------------------------------------
module imm_extract
    import CpuPkg::*;
#(
    parameter int XLEN = 32
) (
    input  imm_type_e       imm_type_i,
    input  inst_t           inst_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    // Every format is first assembled as a 32-bit value that is already
    // correct for XLEN=32; widening to XLEN is then a plain sign extension.
    // CSR is zero-extended into 32 bits, so its bit 31 is 0 and the final
    // sign extension keeps it zero-extended.
    logic [31:0] raw;

    // The opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst_i[6:0];

    always_comb begin
        raw       = '0;
        illegal_o = 1'b0;
        case (imm_type_i)
            IMM_TYPE_I:   raw = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_TYPE_S:   raw = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_TYPE_B:   raw = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                                 inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_TYPE_U:   raw = {inst_i[31:12], 12'b0};
            IMM_TYPE_J:   raw = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                                 inst_i[20], inst_i[30:21], 1'b0};
            IMM_TYPE_CSR: raw = {{(32-IMM_CSR_W){1'b0}}, inst_i[15 +: IMM_CSR_W]};
            default: begin
                raw       = '0;
                illegal_o = 1'b1;
            end
        endcase
        imm_o = XLEN'(signed'(raw));
    end

endmodule : imm_extract

// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
// Registered immediate-decode stage with a 2-entry skid buffer. The immediate
// is extracted combinationally at the input and captured into the output
// register (or the skid register when the output is stalled).
//   i_clk        in  clock, rising edge
//   i_rst_n      in  asynchronous active-low reset
//   bus          slave side of imm_decode_stage_if (flush, both handshakes,
//                instruction/tag in, immediate/tag/illegal out)
//   o_dbg_state  out current buffer occupancy state
// Latency 1 cycle, throughput 1 entry/cycle, o_ready decoded from state only.
// -----------------------------------------------------------------------------
module imm_decode_stage
    import CpuPkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    imm_decode_stage_if.slave  bus,
    output stage_state_e       o_dbg_state
);

    stage_state_e     state_q, state_d;

    logic [XLEN-1:0]  out_imm_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_ill_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic [TAG_W-1:0] skid_tag_q;
    logic             skid_ill_q;

    logic [XLEN-1:0]  ext_imm;
    logic             ext_ill;

    logic             out_valid;
    logic             in_ready;
    logic             accept;
    logic             drain;
    logic             load_out_new;
    logic             load_out_skid;
    logic             load_skid;

    imm_extract #(
        .XLEN (XLEN)
    ) u_imm_extract (
        .imm_type_i (bus.i_imm_type),
        .inst_i     (bus.i_inst),
        .imm_o      (ext_imm),
        .illegal_o  (ext_ill)
    );

    // Both handshake flags come from registered state, which keeps the
    // i_ready -> o_ready path purely sequential.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_FULL);
    assign accept    = bus.i_valid & in_ready;
    assign drain     = out_valid & bus.i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (bus.i_flush) begin
            // Flush discards the buffer and any same-cycle input.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_ONE;
                        load_out_new = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        load_out_new = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d       = ST_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_imm_q  <= '0;
            out_tag_q  <= '0;
            out_ill_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            if (load_out_new) begin
                out_imm_q <= ext_imm;
                out_tag_q <= bus.i_tag;
                out_ill_q <= ext_ill;
            end else if (load_out_skid) begin
                out_imm_q <= skid_imm_q;
                out_tag_q <= skid_tag_q;
                out_ill_q <= skid_ill_q;
            end
            if (load_skid) begin
                skid_imm_q <= ext_imm;
                skid_tag_q <= bus.i_tag;
                skid_ill_q <= ext_ill;
            end
        end
    end

    assign bus.o_valid   = out_valid;
    assign bus.o_ready   = in_ready;
    assign bus.o_imm     = out_imm_q;
    assign bus.o_tag     = out_tag_q;
    assign bus.o_illegal = out_ill_q;
    assign o_dbg_state   = state_q;

endmodule : imm_decode_stage

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, XLEN-parametrised immediate-decode pipeline stage for the decode path. It takes a 32-bit instruction and its immediate type, extracts and sign- or zero-extends the immediate to XLEN, and presents it with a sideband tag.

The input and output use a valid/ready handshake with a 2-entry skid buffer, so `o_ready` never depends combinationally on `i_ready`. It adds deterministic illegal-type flagging and a synchronous flush.

## Interface
- `XLEN`, 32, datapath width; legal values 32 or 64.
- `TAG_W`, 5, width of the sideband tag (e.g. rd index or ROB id) carried alongside the immediate.

Ports:
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  reset; asynchronous assert, active-low.
- `i_flush`  in  1  drop all buffered entries.
- `i_valid`  in  1  upstream offers an instruction.
- `o_ready`  out  1  stage can accept; a function of registered state only.
- `i_imm_type`  in  `imm_type_e`  immediate format: I/S/B/U/J/CSR.
- `i_inst`  in  `inst_t` (32)  raw instruction word.
- `i_tag`  in  `TAG_W`  sideband, passed through unchanged.
- `o_valid`  out  1  output entry present.
- `i_ready`  in  1  downstream accepts.
- `o_imm`  out  `XLEN`  extended immediate.
- `o_tag`  out  `TAG_W`  tag of the output entry.
- `o_illegal`  out  1  output entry had an unsupported `i_imm_type`.

## Operation
Extraction is combinational at the input, and the result is captured in the buffer.

Field rules, with sign bit `inst[31]`:
- I: `inst[31:20]`, sign-extended.
- S: `{inst[31:25], inst[11:7]}`, sign-extended.
- B: `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`, sign-extended.
- U: `{inst[31:12], 12'b0}`, sign-extended to XLEN (bits above 31 copy `inst[31]` when XLEN=64).
- J: `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`, sign-extended.
- CSR: `inst[19:15]`, zero-extended.
- Any other encoding: imm = 0, illegal = 1. No X is ever produced.

Handshake terms: `accept = i_valid & o_ready`; `drain = o_valid & i_ready`.

State machine, 2 bits: EMPTY, ONE (output register full), FULL (output and skid full).
- EMPTY: `o_valid`=0, `o_ready`=1. On accept → ONE, output ← new entry.
- ONE: `o_valid`=1, `o_ready`=1.
  - accept & drain → ONE, output ← new entry.
  - accept & !drain → FULL, skid ← new entry.
  - drain only → EMPTY.
  - neither → hold.
- FULL: `o_valid`=1, `o_ready`=0. On drain → ONE, output ← skid. Otherwise hold.

Flush and stability:
- `i_flush` has priority over everything. The next state is EMPTY, and any same-cycle input is discarded even if `i_valid` and `o_ready` are both 1.
- Entries leave in arrival order; no reordering and no duplication.
- While `o_valid` & !`i_ready`, `o_imm`/`o_tag`/`o_illegal` hold stable.
- Data outputs are don't-care while `o_valid`=0; they keep their last value, with no required clear.

## Timing
- Latency: 1 cycle. An input accepted at edge N is on the output after edge N.
- Throughput: 1 entry per cycle while `i_ready`=1.
- `o_ready` is a registered-state decode: no combinational `i_ready` → `o_ready` path.
- Reset (asynchronous, `i_rst_n`=0) forces state EMPTY, `o_valid`=0, `o_ready`=1, `o_imm`=0, `o_tag`=0, `o_illegal`=0, and skid contents 0.
- Reset mid-transfer loses all entries.
- Capacity: 2 entries. Upstream sees `o_ready`=0 only in FULL.

## Structure
- `imm_type_e` (including `IMM_TYPE_CSR`) and `inst_t` stay in `CpuPkg`.
- Add an `XLEN`-independent constant `IMM_CSR_W = 5` to `CpuPkg`.
- One sub-module, `imm_extract`: purely combinational, parametrised on XLEN, outputs `{imm, illegal}`. It is instantiated once at the input.
- The skid/state logic lives in `imm_decode_stage`.

## Test plan
- **I-type, XLEN=32:** `0xFFF00093` (addi x1,x0,-1), `i_ready`=1. One cycle later: `o_valid`=1, `o_imm`=`0xFFFFFFFF`, `o_tag` echoed.
- **U-type, XLEN=64:** `0x80000037`. `o_imm`=`0xFFFFFFFF80000000`. Also B-type `0xFE000EE3` (beq -4) gives `…FFFC`.
- **CSR:** inst with `[19:15]`=`5'h1F`, other bits all 1. `o_imm`=`0x1F`. An unsupported `i_imm_type` gives `o_imm`=0, `o_illegal`=1.
- **Backpressure:** `i_ready`=0, offer 3 entries on consecutive cycles.
  - The first two are accepted; `o_ready`=0 after the 2nd.
  - The third is held upstream.
  - Releasing `i_ready` drains tags 1, 2, 3 in order with no loss.
- **Flush in FULL with `i_valid`=1 in the same cycle:** next cycle `o_valid`=0, `o_ready`=1, and the new entry never appears.
- **Async reset asserted mid-stream, between clock edges:** outputs go to their reset values immediately. After deassert, the first accepted entry emerges normally.
